traffic_light_monitor: RTL and testbench

- Safety monitor and fail-safe stage placed directly downstream of the four-direction traffic light controller, between controller lamp registers and lamp drivers.
- Passes legal lamp patterns through with one cycle of latency.
- On an illegal pattern or an over-long orange/green phase, it latches a fault and drives all directions flashing red until an operator clear.
- The illegal pattern never reaches the outputs.

---
 rtl/traffic_light_monitor.sv | 235 +++++++++++++++++++++++
 tb/tb_traffic_light_monitor.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/traffic_light_monitor.sv
// Safety monitor and fail-safe stage between the traffic light controller
// lamp registers and the lamp drivers. Legal lamp patterns pass through with
// one cycle of latency; an illegal pattern or an over-long orange/green phase
// latches a fault and forces all directions to flashing red until cleared.
module traffic_light_monitor #(
  parameter int ORANGE_MAX  = 5,
  parameter int GREEN_MAX   = 25,
  parameter int FLASH_HALF  = 4,
  parameter int RECOVER_CYC = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] red_in,
  input  logic [3:0] orange_in,
  input  logic [3:0] green_in,
  input  logic       clear,
  output logic [3:0] red_out,
  output logic [3:0] orange_out,
  output logic [3:0] green_out,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic [1:0] fault_dir
);

  localparam int RW = $clog2(GREEN_MAX + 2);
  localparam int FW = $clog2(2 * FLASH_HALF);
  localparam int CW = $clog2(RECOVER_CYC + 1);

  typedef enum logic [1:0] {
    ST_RECOVER = 2'd0,
    ST_PASS    = 2'd1,
    ST_FAULT   = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   rec_cnt_q, rec_cnt_d;
  logic [FW-1:0]   flash_q, flash_d;
  logic [RW-1:0]   o_cnt_q [4];
  logic [RW-1:0]   o_cnt_d [4];
  logic [RW-1:0]   g_cnt_q [4];
  logic [RW-1:0]   g_cnt_d [4];
  logic [3:0]      red_q, red_d, orange_q, orange_d, green_q, green_d;
  logic            fault_q, fault_d;
  logic [2:0]      code_q, code_d;
  logic [1:0]      dir_q, dir_d;

  logic            any_viol_s;
  logic [2:0]      viol_code_s;
  logic [1:0]      viol_dir_s;

  // Combinational rule checks on the current inputs, resolved by priority.
  always_comb begin
    logic [2:0] red_low_n;
    logic       conf_v, lamp_v, grn_v, org_v;
    logic [1:0] conf_dir, lamp_dir, grn_dir, org_dir;
    red_low_n = 3'd0;
    conf_v = 1'b0; lamp_v = 1'b0; grn_v = 1'b0; org_v = 1'b0;
    conf_dir = 2'd0; lamp_dir = 2'd0; grn_dir = 2'd0; org_dir = 2'd0;
    // Descending scan so the lowest implicated index is the one kept.
    for (int i = 3; i >= 0; i--) begin
      red_low_n = red_low_n + {2'b00, ~red_in[i]};
      if (!red_in[i]) begin
        conf_dir = 2'(i);
      end else begin
        conf_dir = conf_dir;
      end
      if ((2'({1'b0, red_in[i]}) + 2'({1'b0, orange_in[i]}) + 2'({1'b0, green_in[i]})) != 2'd1) begin
        lamp_v   = 1'b1;
        lamp_dir = 2'(i);
      end else begin
        lamp_v   = lamp_v;
      end
      // The incremented run length reaching MAX+1 is a timeout.
      if (green_in[i] && (g_cnt_q[i] >= RW'(GREEN_MAX))) begin
        grn_v   = 1'b1;
        grn_dir = 2'(i);
      end else begin
        grn_v   = grn_v;
      end
      if (orange_in[i] && (o_cnt_q[i] >= RW'(ORANGE_MAX))) begin
        org_v   = 1'b1;
        org_dir = 2'(i);
      end else begin
        org_v   = org_v;
      end
    end
    conf_v = (red_low_n >= 3'd2);
    any_viol_s  = conf_v | lamp_v | grn_v | org_v;
    viol_code_s = 3'd0;
    viol_dir_s  = 2'd0;
    if (conf_v) begin
      viol_code_s = 3'd2; viol_dir_s = conf_dir;
    end else if (lamp_v) begin
      viol_code_s = 3'd1; viol_dir_s = lamp_dir;
    end else if (grn_v) begin
      viol_code_s = 3'd4; viol_dir_s = grn_dir;
    end else if (org_v) begin
      viol_code_s = 3'd3; viol_dir_s = org_dir;
    end else begin
      viol_code_s = 3'd0; viol_dir_s = 2'd0;
    end
  end

  // Next-state logic of the RECOVER / PASS / FAULT controller.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RECOVER: begin
        if (rec_cnt_q == CW'(RECOVER_CYC - 1)) state_d = ST_PASS;
        else                                   state_d = ST_RECOVER;
      end
      ST_PASS: begin
        if (any_viol_s) state_d = ST_FAULT;
        else            state_d = ST_PASS;
      end
      ST_FAULT: begin
        if (clear) state_d = ST_RECOVER;
        else       state_d = ST_FAULT;
      end
      default: state_d = ST_RECOVER;
    endcase
  end

  // Output, counter and sticky-cause next values for each state.
  always_comb begin
    red_d     = red_q;
    orange_d  = orange_q;
    green_d   = green_q;
    fault_d   = fault_q;
    code_d    = code_q;
    dir_d     = dir_q;
    rec_cnt_d = rec_cnt_q;
    flash_d   = flash_q;
    for (int i = 0; i < 4; i++) begin
      o_cnt_d[i] = RW'(0);
      g_cnt_d[i] = RW'(0);
    end
    case (state_q)
      ST_RECOVER: begin
        red_d     = 4'b1111;
        orange_d  = 4'b0000;
        green_d   = 4'b0000;
        fault_d   = 1'b0;
        rec_cnt_d = rec_cnt_q + CW'(1);
      end
      ST_PASS: begin
        rec_cnt_d = CW'(0);
        if (any_viol_s) begin
          red_d    = 4'b1111;
          orange_d = 4'b0000;
          green_d  = 4'b0000;
          fault_d  = 1'b1;
          code_d   = viol_code_s;
          dir_d    = viol_dir_s;
          flash_d  = FW'(0);
        end else begin
          red_d    = red_in;
          orange_d = orange_in;
          green_d  = green_in;
          for (int i = 0; i < 4; i++) begin
            if (!orange_in[i])                          o_cnt_d[i] = RW'(0);
            else if (o_cnt_q[i] == RW'(ORANGE_MAX + 1)) o_cnt_d[i] = o_cnt_q[i];
            else                                        o_cnt_d[i] = o_cnt_q[i] + RW'(1);
            if (!green_in[i])                           g_cnt_d[i] = RW'(0);
            else if (g_cnt_q[i] == RW'(GREEN_MAX + 1))  g_cnt_d[i] = g_cnt_q[i];
            else                                        g_cnt_d[i] = g_cnt_q[i] + RW'(1);
          end
        end
      end
      ST_FAULT: begin
        orange_d = 4'b0000;
        green_d  = 4'b0000;
        if (clear) begin
          red_d     = 4'b1111;
          fault_d   = 1'b0;
          rec_cnt_d = CW'(0);
        end else begin
          // The entry cycle counts as the first cycle of the on-phase.
          if (flash_q == FW'(2 * FLASH_HALF - 1)) flash_d = FW'(0);
          else                                    flash_d = flash_q + FW'(1);
          if (flash_d < FW'(FLASH_HALF)) red_d = 4'b1111;
          else                           red_d = 4'b0000;
        end
      end
      default: begin
        red_d     = 4'b1111;
        orange_d  = 4'b0000;
        green_d   = 4'b0000;
        fault_d   = 1'b0;
        rec_cnt_d = CW'(0);
      end
    endcase
  end

  // State and output registers with synchronous reset into RECOVER.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_RECOVER;
      rec_cnt_q <= CW'(0);
      flash_q   <= FW'(0);
      red_q     <= 4'b1111;
      orange_q  <= 4'b0000;
      green_q   <= 4'b0000;
      fault_q   <= 1'b0;
      code_q    <= 3'd0;
      dir_q     <= 2'd0;
      for (int i = 0; i < 4; i++) begin
        o_cnt_q[i] <= RW'(0);
        g_cnt_q[i] <= RW'(0);
      end
    end else begin
      state_q   <= state_d;
      rec_cnt_q <= rec_cnt_d;
      flash_q   <= flash_d;
      red_q     <= red_d;
      orange_q  <= orange_d;
      green_q   <= green_d;
      fault_q   <= fault_d;
      code_q    <= code_d;
      dir_q     <= dir_d;
      for (int i = 0; i < 4; i++) begin
        o_cnt_q[i] <= o_cnt_d[i];
        g_cnt_q[i] <= g_cnt_d[i];
      end
    end
  end

  assign red_out    = red_q;
  assign orange_out = orange_q;
  assign green_out  = green_q;
  assign fault      = fault_q;
  assign fault_code = code_q;
  assign fault_dir  = dir_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed testbench for traffic_light_monitor: inputs change on the falling
// edge, outputs are checked on the following falling edge.
module tb_traffic_light_monitor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] red_in = 4'b1111;
  logic [3:0] orange_in = 4'b0000;
  logic [3:0] green_in = 4'b0000;
  logic       clear = 1'b0;
  logic [3:0] red_out, orange_out, green_out;
  logic       fault;
  logic [2:0] fault_code;
  logic [1:0] fault_dir;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  traffic_light_monitor dut (
    .clk        (clk),
    .rst        (rst),
    .red_in     (red_in),
    .orange_in  (orange_in),
    .green_in   (green_in),
    .clear      (clear),
    .red_out    (red_out),
    .orange_out (orange_out),
    .green_out  (green_out),
    .fault      (fault),
    .fault_code (fault_code),
    .fault_dir  (fault_dir)
  );

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Apply one input vector and wait one cycle.
  task automatic apply(input logic [3:0] r, input logic [3:0] o, input logic [3:0] g);
    red_in = r; orange_in = o; green_in = g;
    @(negedge clk);
  endtask

  // Apply a legal vector and expect it delayed by one cycle, no fault.
  task automatic pass_chk(input string tag, input logic [3:0] r, input logic [3:0] o, input logic [3:0] g);
    apply(r, o, g);
    chk({tag, "_red"}, {4'b0, red_out}, {4'b0, r});
    chk({tag, "_org"}, {4'b0, orange_out}, {4'b0, o});
    chk({tag, "_grn"}, {4'b0, green_out}, {4'b0, g});
    chk({tag, "_flt"}, {7'b0, fault}, 8'd0);
  endtask

  task automatic fault_chk(input string tag, input logic [2:0] code, input logic [1:0] dir);
    chk({tag, "_flt"},  {7'b0, fault}, 8'd1);
    chk({tag, "_code"}, {5'b0, fault_code}, {5'b0, code});
    chk({tag, "_dir"},  {6'b0, fault_dir}, {6'b0, dir});
    chk({tag, "_red"},  {4'b0, red_out}, 8'h0f);
    chk({tag, "_og"},   {orange_out, green_out}, 8'h00);
  endtask

  // Eight solid-red cycles while a non-red legal vector is driven.
  task automatic recover_chk(input string tag, input logic [2:0] code, input bit clear_again);
    for (int j = 0; j < 8; j++) begin
      clear = (clear_again && j == 2) ? 1'b1 : 1'b0;
      apply(4'b1110, 4'b0000, 4'b0001);
      chk({tag, "_rec_red"}, {4'b0, red_out}, 8'h0f);
      chk({tag, "_rec_grn"}, {4'b0, green_out}, 8'h00);
      chk({tag, "_rec_flt"}, {7'b0, fault}, 8'd0);
      chk({tag, "_rec_code"}, {5'b0, fault_code}, {5'b0, code});
    end
    clear = 1'b0;
    pass_chk({tag, "_resume"}, 4'b1110, 4'b0000, 4'b0001);
  endtask

  task automatic clear_chk(input string tag, input logic [2:0] code);
    clear = 1'b1;
    apply(4'b1111, 4'b0000, 4'b0000);
    clear = 1'b0;
    chk({tag, "_clr_flt"}, {7'b0, fault}, 8'd0);
    chk({tag, "_clr_red"}, {4'b0, red_out}, 8'h0f);
    recover_chk(tag, code, 1'b0);
  endtask

  initial begin
    // Reset
    @(negedge clk);
    @(negedge clk);
    chk("rst_red", {4'b0, red_out}, 8'h0f);
    chk("rst_og", {orange_out, green_out}, 8'h00);
    chk("rst_flt", {7'b0, fault}, 8'd0);
    chk("rst_code", {5'b0, fault_code}, 8'd0);
    chk("rst_dir", {6'b0, fault_dir}, 8'd0);
    rst = 1'b0;

    // Recovery after reset: inputs ignored, solid red
    for (int j = 0; j < 8; j++) begin
      apply(4'b1110, 4'b0001, 4'b0000);
      chk("init_rec_red", {4'b0, red_out}, 8'h0f);
      chk("init_rec_org", {4'b0, orange_out}, 8'h00);
    end
    // Legal sequence: dir1 orange 5, green 25, dir2 orange
    for (int j = 0; j < 5; j++)  pass_chk("leg_org1", 4'b1110, 4'b0001, 4'b0000);
    for (int j = 0; j < 25; j++) pass_chk("leg_grn1", 4'b1110, 4'b0000, 4'b0001);
    for (int j = 0; j < 3; j++)  pass_chk("leg_org2", 4'b1101, 4'b0010, 4'b0000);
    pass_chk("leg_allred", 4'b1111, 4'b0000, 4'b0000);

    // Conflict: dirs 1 and 2 green
    apply(4'b1100, 4'b0000, 4'b0011);
    fault_chk("conf", 3'd2, 2'd0);
    // Flash: entry cycle is on-phase cycle 0
    for (int k = 1; k < 12; k++) begin
      apply(4'b1100, 4'b0000, 4'b0011);
      chk("flash_red", {4'b0, red_out}, ((k % 8) < 4) ? 8'h0f : 8'h00);
      chk("flash_flt", {7'b0, fault}, 8'd1);
      chk("flash_g", {4'b0, green_out}, 8'h00);
    end
    // Clear, with a second clear during recovery that must be ignored
    clear = 1'b1;
    apply(4'b1111, 4'b0000, 4'b0000);
    clear = 1'b0;
    chk("clr1_flt", {7'b0, fault}, 8'd0);
    chk("clr1_red", {4'b0, red_out}, 8'h0f);
    chk("clr1_code", {5'b0, fault_code}, 8'd2);
    recover_chk("clr1", 3'd2, 1'b1);

    // Orange dir3: 5 cycles legal, then 6 cycles faults on the 6th
    for (int j = 0; j < 5; j++) pass_chk("org5", 4'b1011, 4'b0100, 4'b0000);
    pass_chk("org_gap", 4'b1111, 4'b0000, 4'b0000);
    for (int j = 0; j < 5; j++) pass_chk("org6", 4'b1011, 4'b0100, 4'b0000);
    apply(4'b1011, 4'b0100, 4'b0000);
    fault_chk("org_to", 3'd3, 2'd2);
    clear_chk("clr2", 3'd3);

    // Lamp-count: dir2 red and orange together
    apply(4'b1111, 4'b0010, 4'b0000);
    fault_chk("lamp", 3'd1, 2'd1);
    clear_chk("clr3", 3'd1);

    // Green dir3: 25 legal, 26th faults
    for (int j = 0; j < 25; j++) pass_chk("grn25", 4'b1011, 4'b0000, 4'b0100);
    apply(4'b1011, 4'b0000, 4'b0100);
    fault_chk("grn_to", 3'd4, 2'd2);
    clear_chk("clr4", 3'd4);

    // Dir3 red+green, dir1 green: conflict beats lamp-count
    apply(4'b0100, 4'b0000, 4'b0101);
    fault_chk("prio", 3'd2, 2'd0);

    // Reset together with clear while in FAULT
    rst = 1'b1;
    clear = 1'b1;
    apply(4'b1111, 4'b0000, 4'b0000);
    chk("rstclr_flt", {7'b0, fault}, 8'd0);
    chk("rstclr_code", {5'b0, fault_code}, 8'd0);
    chk("rstclr_dir", {6'b0, fault_dir}, 8'd0);
    chk("rstclr_red", {4'b0, red_out}, 8'h0f);
    rst = 1'b0;
    clear = 1'b0;
    recover_chk("rst2", 3'd0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
